// File: rtl/mult_div_unit_pkg.sv
// Shared constants: ALU/MDU op codes, MDU state encoding, cycle defaults.
// Accumulate ops are only accepted when MDU_ACCUM_EN is defined.
package mult_div_unit_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR,
    ALU_XOR, ALU_NOR, ALU_SLT, ALU_SLTU,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_e;

  typedef enum logic [3:0] {
    MD_NONE = 4'd0,
    MULT    = 4'd1,
    MULTU   = 4'd2,
    DIV     = 4'd3,
    DIVU    = 4'd4,
    MTHI    = 4'd5,
    MTLO    = 4'd6,
    MADD    = 4'd7,
    MADDU   = 4'd8,
    MSUB    = 4'd9,
    MSUBU   = 4'd10
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    DIV_RUN
  } md_state_e;

  localparam int MD_MULT_CYCLES_DEF = 5;
  localparam int MD_DIV_CYCLES_DEF  = 10;
  localparam int MD_CNT_W           = 5;

endpackage

// File: rtl/mult_div_unit_if.sv
// MDU issue/result bundle: start, op, rs_data, rt_data in; busy, hi, lo out.
// master = issuing pipeline, slave = mult_div_unit.
interface mult_div_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic             busy;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data,
    output busy, hi, lo
  );
endinterface

// File: rtl/mult_div_unit_datapath.sv
// md_datapath: combinational product/quotient/remainder/accumulate.
// Ports: op_i, a_i, b_i, hi_i, lo_i in; wr_o, hi_o, lo_o out (MDU_ACCUM_EN).
module md_datapath
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  md_op_e           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic             wr_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int W2 = 2 * WIDTH;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};

  logic             sgn;
  logic             dz;
  logic             ovf;
  logic [W2-1:0]    a_x;
  logic [W2-1:0]    b_x;
  logic [W2-1:0]    prod;
  logic [WIDTH-1:0] dv;
  logic [WIDTH-1:0] sq;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] uq;
  logic [WIDTH-1:0] ur;

  always_comb begin
    sgn = (op_i == MULT) || (op_i == DIV) ||
          (op_i == MADD) || (op_i == MSUB);
    a_x = sgn ? {{WIDTH{a_i[WIDTH-1]}}, a_i}
              : {{WIDTH{1'b0}}, a_i};
    b_x = sgn ? {{WIDTH{b_i[WIDTH-1]}}, b_i}
              : {{WIDTH{1'b0}}, b_i};
    prod = a_x * b_x;
    dz  = (b_i == '0);
    ovf = (op_i == DIV) && (a_i == MIN) && (b_i == '1);
    // MIN / -1 is rerouted to MIN / 1, which yields the
    // wrapped quotient MIN and remainder 0 without overflow.
    dv = (dz || ovf) ? ONE : b_i;
    sq = $signed(a_i) / $signed(dv);
    sr = $signed(a_i) % $signed(dv);
    uq = a_i / dv;
    ur = a_i % dv;
  end

  always_comb begin
    wr_o = 1'b0;
    hi_o = hi_i;
    lo_o = lo_i;
    unique case (op_i)
      MULT, MULTU: begin
        wr_o = 1'b1;
        {hi_o, lo_o} = prod;
      end
      DIV: begin
        wr_o = !dz;
        hi_o = sr;
        lo_o = sq;
      end
      DIVU: begin
        wr_o = !dz;
        hi_o = ur;
        lo_o = uq;
      end
`ifdef MDU_ACCUM_EN
      MADD, MADDU: begin
        wr_o = 1'b1;
        {hi_o, lo_o} = {hi_i, lo_i} + prod;
      end
      MSUB, MSUBU: begin
        wr_o = 1'b1;
        {hi_o, lo_o} = {hi_i, lo_i} - prod;
      end
`endif
      default: begin
        wr_o = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// MDU control: FSM, busy counter, HI/LO registers; clk, reset + md bundle.
// MDU_ACCUM_EN enables MADD/MADDU/MSUB/MSUBU; otherwise they are ignored.
module mult_div_unit
  import mult_div_unit_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  md
);

  localparam logic [MD_CNT_W-1:0] CNT_ONE = MD_CNT_W'(1);

  md_state_e            state_q, state_d;
  logic [MD_CNT_W-1:0]  cnt_q, cnt_d;
  md_op_e               op_q, op_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;

  md_op_e               op_in;
  logic                 is_mul;
  logic                 is_div;
  logic                 dp_wr;
  logic [WIDTH-1:0]     dp_hi;
  logic [WIDTH-1:0]     dp_lo;

  md_datapath #(
    .WIDTH (WIDTH)
  ) u_dp (
    .op_i (op_q),
    .a_i  (a_q),
    .b_i  (b_q),
    .hi_i (hi_q),
    .lo_i (lo_q),
    .wr_o (dp_wr),
    .hi_o (dp_hi),
    .lo_o (dp_lo)
  );

  always_comb begin
    op_in  = md_op_e'(md.op);
    is_mul = (op_in == MULT) || (op_in == MULTU);
`ifdef MDU_ACCUM_EN
    is_mul = is_mul ||
             (op_in == MADD) || (op_in == MADDU) ||
             (op_in == MSUB) || (op_in == MSUBU);
`endif
    is_div = (op_in == DIV) || (op_in == DIVU);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      IDLE: begin
        if (md.start && is_mul) begin
          state_d = MUL_RUN;
          cnt_d   = MD_CNT_W'(MULT_CYCLES);
          op_d    = op_in;
          a_d     = md.rs_data;
          b_d     = md.rt_data;
        end else if (md.start && is_div) begin
          state_d = DIV_RUN;
          cnt_d   = MD_CNT_W'(DIV_CYCLES);
          op_d    = op_in;
          a_d     = md.rs_data;
          b_d     = md.rt_data;
        end else if (!md.start && op_in == MTHI) begin
          hi_d = md.rs_data;
        end else if (!md.start && op_in == MTLO) begin
          lo_d = md.rs_data;
        end
      end
      MUL_RUN, DIV_RUN: begin
        if (cnt_q == CNT_ONE) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (dp_wr) begin
            hi_d = dp_hi;
            lo_d = dp_lo;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MD_NONE;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign md.busy = (state_q != IDLE);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, results, interlock, reset.
// Define MDU_ACCUM_EN to expect accumulate ops to take effect.
module tb_mult_div_unit;
  import mult_div_unit_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  mult_div_unit_if #(.WIDTH(32)) md();

  mult_div_unit #(
    .WIDTH       (32),
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // HI/LO must hold while an op stays in flight.
  logic        busy_p = 1'b0;
  logic [31:0] hi_p, lo_p;
  always @(negedge clk) begin
    if (busy_p === 1'b1 && md.busy === 1'b1) begin
      chk("hold_hi", md.hi, hi_p);
      chk("hold_lo", md.lo, lo_p);
    end
    busy_p = md.busy;
    hi_p   = md.hi;
    lo_p   = md.lo;
  end

  task automatic issue(input logic [3:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b);
    @(negedge clk);
    md.start   = 1'b1;
    md.op      = op;
    md.rs_data = a;
    md.rt_data = b;
    @(negedge clk);
    md.start = 1'b0;
    md.op    = MD_NONE;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (md.busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic run(input string tag,
                     input logic [3:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input int n_exp,
                     input logic [31:0] hi_exp,
                     input logic [31:0] lo_exp);
    int n;
    issue(op, a, b);
    wait_idle(n);
    chk({tag, "_len"}, n, n_exp);
    chk({tag, "_hi"}, md.hi, hi_exp);
    chk({tag, "_lo"}, md.lo, lo_exp);
  endtask

  task automatic mt(input logic [3:0] op,
                    input logic [31:0] v);
    @(negedge clk);
    md.start   = 1'b0;
    md.op      = op;
    md.rs_data = v;
    @(negedge clk);
    md.op = MD_NONE;
  endtask

  initial begin
    int n;
    md.start   = 1'b0;
    md.op      = MD_NONE;
    md.rs_data = '0;
    md.rt_data = '0;
    reset      = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(md.busy), 32'h0);
    chk("rst_hi", md.hi, 32'h0);
    chk("rst_lo", md.lo, 32'h0);
    reset = 1'b0;

    @(negedge clk);
    md.op      = MTHI;
    md.rs_data = 32'h1234;
    @(negedge clk);
    md.op      = MTLO;
    md.rs_data = 32'h5678;
    chk("mthi_busy", 32'(md.busy), 32'h0);
    chk("mthi_hi", md.hi, 32'h1234);
    @(negedge clk);
    md.op = MD_NONE;
    chk("mtlo_busy", 32'(md.busy), 32'h0);
    chk("mt_hi", md.hi, 32'h1234);
    chk("mt_lo", md.lo, 32'h5678);

    run("mult_neg", MULT, 32'hFFFF_FFFF, 32'h2, 5,
        32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("multu", MULTU, 32'hFFFF_FFFF, 32'h2, 5,
        32'h1, 32'hFFFF_FFFE);
    run("mult_max", MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 5,
        32'h3FFF_FFFF, 32'h0000_0001);
    run("div_neg", DIV, 32'hFFFF_FFF9, 32'h2, 10,
        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("divu_z", DIVU, 32'h7, 32'h0, 10,
        32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 10,
        32'h0, 32'h8000_0000);
    run("divu", DIVU, 32'hFFFF_FFFF, 32'hA, 10,
        32'h5, 32'h1999_9999);
    run("div_negd", DIV, 32'h7, 32'hFFFF_FFFE, 10,
        32'h1, 32'hFFFF_FFFD);

    // MULT in third busy cycle and MTHI in fourth: both ignored.
    issue(DIV, 32'd100, 32'd7);
    @(negedge clk);
    @(negedge clk);
    md.start   = 1'b1;
    md.op      = MULT;
    md.rs_data = 32'h3;
    md.rt_data = 32'h3;
    @(negedge clk);
    md.start   = 1'b0;
    md.op      = MTHI;
    md.rs_data = 32'hDEAD;
    @(negedge clk);
    md.op = MD_NONE;
    wait_idle(n);
    chk("ilk_len", n + 4, 10);
    chk("ilk_hi", md.hi, 32'h2);
    chk("ilk_lo", md.lo, 32'hE);

    // Reset in second busy cycle of a MULT aborts it.
    issue(MULT, 32'h3, 32'h3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(md.busy), 32'h0);
    chk("abort_hi", md.hi, 32'h0);
    chk("abort_lo", md.lo, 32'h0);
    repeat (8) @(negedge clk);
    chk("abort_busy2", 32'(md.busy), 32'h0);
    chk("abort_hi2", md.hi, 32'h0);
    chk("abort_lo2", md.lo, 32'h0);

    mt(MTHI, 32'h0);
    mt(MTLO, 32'hFFFF_FFFF);
`ifdef MDU_ACCUM_EN
    run("maddu", MADDU, 32'h1, 32'h1, 5,
        32'h1, 32'h0);
    run("msub", MSUB, 32'h1, 32'h1, 5,
        32'h0, 32'hFFFF_FFFF);
`else
    run("maddu", MADDU, 32'h1, 32'h1, 0,
        32'h0, 32'hFFFF_FFFF);
    run("msub", MSUB, 32'h1, 32'h1, 0,
        32'h0, 32'hFFFF_FFFF);
`endif
    run("none", MD_NONE, 32'h5, 32'h5, 0,
        32'h0, 32'hFFFF_FFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
